mips_mem_port: RTL and testbench

//  Memory-side stage for the multicycle MIPS core. Consumes MemRead/MemWrite/IRWrite/IorD

---
 rtl/mips_mem_port_if.sv | 23 ++
 rtl/mips_mem_port.sv | 161 ++++++++++++++++
 tb/tb_mips_mem_port.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_mem_port_if.sv
// Request/acknowledge bus between the MIPS memory port and single-port unified memory.
// The master modport is the core side; the slave modport is the memory side.
interface mips_mem_port_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mips_mem_port.sv
// Memory-side stage of the multicycle MIPS core: req/ack handshake, IR, MDR and stall.
// Optional macro MEM_PORT_ALIGN_CHECK_EN rejects word-misaligned addresses without a bus request.
module mips_mem_port #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              ir_write,
  input  logic              i_or_d,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [DATA_W-1:0] wdata,
  mips_mem_port_if.master   bus,
  output logic [DATA_W-1:0] ir,
  output logic [5:0]        opcode,
  output logic [5:0]        func,
  output logic [DATA_W-1:0] mdr,
  output logic              stall,
  output logic              bus_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q,     state_d;
  logic              mem_req_q,   mem_req_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] ir_q,        ir_d;
  logic [DATA_W-1:0] mdr_q,       mdr_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic              ir_pend_q,   ir_pend_d;
  logic              bus_err_q,   bus_err_d;

  logic              start;
  logic              misaligned;
  logic              stall_c;
  logic [ADDR_W-1:0] addr_sel;
  logic [CNT_W-1:0]  cnt_inc;

  assign start    = mem_read | mem_write;
  assign addr_sel = i_or_d ? alu_out : pc;
  assign cnt_inc  = cnt_q + CNT_W'(1);

`ifdef MEM_PORT_ALIGN_CHECK_EN
  assign misaligned = (addr_sel[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // NOTE: every variable gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ir_d        = ir_q;
    mdr_d       = mdr_q;
    cnt_d       = cnt_q;
    ir_pend_d   = ir_pend_q;
    bus_err_d   = bus_err_q;
    stall_c     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          stall_c = 1'b1;
          if (misaligned) begin
            bus_err_d = 1'b1;
            state_d   = DONE;
          end else begin
            mem_addr_d  = addr_sel;
            mem_wdata_d = wdata;
            mem_we_d    = mem_write & ~mem_read;
            ir_pend_d   = ir_write;
            mem_req_d   = 1'b1;
            cnt_d       = '0;
            state_d     = REQ;
            // A simultaneous read and write is carried out as a read but flagged.
            if (mem_read && mem_write) bus_err_d = 1'b1;
          end
        end
      end

      REQ: begin
        stall_c = 1'b1;
        if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            mdr_d = bus.mem_rdata;
            if (ir_pend_q) ir_d = bus.mem_rdata;
          end
          state_d = DONE;
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          mem_req_d = 1'b0;
          bus_err_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      // The controller still presents the same access here; it is deliberately not restarted.
      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ir_q        <= '0;
      mdr_q       <= '0;
      cnt_q       <= '0;
      ir_pend_q   <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ir_q        <= ir_d;
      mdr_q       <= mdr_d;
      cnt_q       <= cnt_d;
      ir_pend_q   <= ir_pend_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  assign ir      = ir_q;
  assign opcode  = ir_q[31:26];
  assign func    = ir_q[5:0];
  assign mdr     = mdr_q;
  assign bus_err = bus_err_q;
  // Reset must release the core immediately, even while the controller still requests.
  assign stall   = rst & stall_c;

endmodule

// File: tb/tb_mips_mem_port.sv
// Self-checking bench for mips_mem_port: requests are scoreboarded against expected bus
// transactions, and stall length, IR, MDR and bus_err are checked after each access.
module tb_mips_mem_port;

  localparam int TMO = 8;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } req_t;

  logic        clk;
  logic        rst;
  logic        mem_read, mem_write, ir_write, i_or_d;
  logic [31:0] pc, alu_out, wdata;
  logic [31:0] ir, mdr;
  logic [5:0]  opcode, func;
  logic        stall, bus_err;

  mips_mem_port_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mips_mem_port #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .ir_write (ir_write),
    .i_or_d   (i_or_d),
    .pc       (pc),
    .alu_out  (alu_out),
    .wdata    (wdata),
    .bus      (bus),
    .ir       (ir),
    .opcode   (opcode),
    .func     (func),
    .mdr      (mdr),
    .stall    (stall),
    .bus_err  (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  req_t        exp_q[$];
  req_t        cur;
  logic        prev_req = 1'b0;
  logic [31:0] exp_ir  = '0;
  logic [31:0] exp_mdr = '0;
  logic        exp_err = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bus monitor: each new request is matched against the scoreboard and must stay stable.
  always @(negedge clk) begin
    if (!rst) begin
      prev_req = 1'b0;
    end else if (bus.mem_req) begin
      if (!prev_req) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_req", bus.mem_req, 1'b0);
        end else begin
          cur = exp_q.pop_front();
          check("sb_addr",  bus.mem_addr,  cur.addr);
          check("sb_we",    bus.mem_we,    cur.we);
          if (cur.we) check("sb_wdata", bus.mem_wdata, cur.wdata);
        end
      end else begin
        check("hold_req", {bus.mem_addr, bus.mem_we, bus.mem_wdata}, {cur.addr, cur.we, cur.wdata});
      end
      prev_req = 1'b1;
    end else begin
      prev_req = 1'b0;
    end
  end

  task automatic check_outputs(input string tag);
    check({tag, "_ir"},     ir,      exp_ir);
    check({tag, "_opcode"}, opcode,  exp_ir[31:26]);
    check({tag, "_func"},   func,    exp_ir[5:0]);
    check({tag, "_mdr"},    mdr,     exp_mdr);
    check({tag, "_err"},    bus_err, exp_err);
  endtask

  // One controller access; ack_at is the REQ cycle (1-based) carrying mem_ack, <1 for never.
  task automatic access(input logic rd, input logic wr, input logic irw, input logic iord,
                        input logic [31:0] pcv, input logic [31:0] aluv,
                        input logic [31:0] wdv, input logic [31:0] rdv,
                        input int ack_at, input string tag);
    logic [31:0] addr;
    logic        misal;
    logic        acked;
    int          reqn;
    int          nstall;
    int          exp_stall;
    logic        done;
    addr  = iord ? aluv : pcv;
    misal = 1'b0;
`ifdef MEM_PORT_ALIGN_CHECK_EN
    misal = (addr[1:0] != 2'b00);
`endif
    acked = !misal && ack_at >= 1 && ack_at <= TMO;
    if (misal)      exp_stall = 1;
    else if (acked) exp_stall = 1 + ack_at;
    else            exp_stall = 1 + TMO;
    if (!misal) exp_q.push_back(req_t'{addr, wr & ~rd, wdv});

    @(negedge clk);
    mem_read = rd; mem_write = wr; ir_write = irw; i_or_d = iord;
    pc = pcv; alu_out = aluv; wdata = wdv; bus.mem_rdata = rdv;
    reqn = 0; nstall = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c > 0) @(negedge clk);
      if (bus.mem_req) reqn++;
      bus.mem_ack = bus.mem_req && (reqn == ack_at);
      #1;
      if (stall) nstall++;
      else       done = 1'b1;
    end
    bus.mem_ack = 1'b0;
    check({tag, "_finished"}, done, 1'b1);
    check({tag, "_stall_cycles"}, nstall, exp_stall);

    if (misal || (rd && wr) || !acked) exp_err = 1'b1;
    if (acked && rd) begin
      exp_mdr = rdv;
      if (irw) exp_ir = rdv;
    end
    check({tag, "_done_req"}, bus.mem_req, 1'b0);
    check_outputs(tag);

    // Controller inputs are still high through DONE; no new request may start from them.
    @(negedge clk);
    check({tag, "_no_restart"}, bus.mem_req, 1'b0);
    mem_read = 1'b0; mem_write = 1'b0; ir_write = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; ir_write = 1'b0; i_or_d = 1'b0;
    pc = '0; alu_out = '0; wdata = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;

    #3 mem_read = 1'b1;
    #1;
    check("rst_stall_forced", stall, 1'b0);
    check("rst_req",  bus.mem_req, 1'b0);
    check("rst_we",   bus.mem_we,  1'b0);
    check("rst_addr", bus.mem_addr, 32'h0);
    check_outputs("rst");
    mem_read = 1'b0;
    @(negedge clk); #2 rst = 1'b1;

    access(1'b1, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0,   32'h0,        32'h8C220004, 1, "fetch");
    access(1'b0, 1'b1, 1'b0, 1'b1, 32'h0,  32'h100, 32'hDEADBEEF, 32'hFFFFFFFF, 4, "store");
    access(1'b1, 1'b0, 1'b0, 1'b1, 32'h0,  32'h104, 32'h5555AAAA, 32'hCAFEF00D, 3, "load");
    access(1'b1, 1'b1, 1'b0, 1'b1, 32'h0,  32'h108, 32'h11111111, 32'h0BADF00D, 1, "both_rw");
    access(1'b1, 1'b0, 1'b1, 1'b0, 32'h44, 32'h0,   32'h0,        32'h77777777, 0, "timeout");

    // Reset while a read is outstanding: request and stall drop at once, late ack ignored.
    exp_q.push_back(req_t'{32'h200, 1'b0, 32'h0});
    @(negedge clk);
    mem_read = 1'b1; ir_write = 1'b1; i_or_d = 1'b1; alu_out = 32'h200;
    bus.mem_rdata = 32'h12345678;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    exp_ir = '0; exp_mdr = '0; exp_err = 1'b0;
    check("rstmid_req",   bus.mem_req, 1'b0);
    check("rstmid_stall", stall,       1'b0);
    check_outputs("rstmid");
    @(negedge clk);
    mem_read = 1'b0; ir_write = 1'b0; i_or_d = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1;
    check("late_ack_req",   bus.mem_req, 1'b0);
    check("late_ack_stall", stall,       1'b0);
    check_outputs("late_ack");

    access(1'b1, 1'b0, 1'b0, 1'b1, 32'h0,  32'h102, 32'h0, 32'h600DCAFE, 1, "align");
    access(1'b1, 1'b0, 1'b1, 1'b0, 32'h48, 32'h0,   32'h0, 32'h00851020, 2, "fetch2");

    check("sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
